// File: rtl/word_sum_arbiter.sv
// word_sum_arbiter: round-robin arbiter sharing one digit-sum datapath among R
// requesters. The granted word's digit sum is registered on a valid/ready result
// port together with the id of the requester that supplied it.
module word_sum_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned R     = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [R-1:0]       req_valid_i,
  input  logic [R*2*N-1:0]   req_word_i,
  output logic [R-1:0]       req_ready_o,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [9:0]         res_sum_o,
  output logic [ID_W-1:0]    res_id_o,
  output logic [CNT_W-1:0]   served_cnt_o,
  output logic               busy_o
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [9:0]       res_sum_q, res_sum_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [CNT_W-1:0] served_cnt_q, served_cnt_d;

  logic             can_accept;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic             grant;
  logic [2*N-1:0]   grant_word;
  logic [9:0]       word_sum;

  // A full result register can only take a new word if it is drained this cycle.
  assign can_accept = (state_q == StEmpty) | res_ready_i;
  assign grant      = can_accept & grant_found & ~rst_i;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping mod R.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < R; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= R) cand = cand - R;
      if (!grant_found && req_valid_i[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Word selection and digit summation for the granted requester.
  always_comb begin
    grant_word = req_word_i[int'(grant_idx)*2*N +: 2*N];
    word_sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      word_sum = word_sum + 10'(grant_word[2*k +: 2]);
    end
  end

  // One-hot ready toward the granted requester.
  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[grant_idx] = 1'b1;
  end

  // Datapath next-state: capture on grant, otherwise hold.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    res_sum_d    = res_sum_q;
    res_id_d     = res_id_q;
    served_cnt_d = served_cnt_q;
    if (grant) begin
      res_sum_d    = word_sum;
      res_id_d     = grant_idx;
      rr_ptr_d     = (grant_idx == ID_W'(R - 1)) ? '0 : grant_idx + 1'b1;
      served_cnt_d = served_cnt_q + 1'b1;
    end
  end

  // FSM next-state: EMPTY/FULL tracks occupancy of the result register.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant) state_d = StFull;
      StFull: begin
        if (grant)            state_d = StFull;
        else if (res_ready_i) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StEmpty;
      rr_ptr_q     <= '0;
      res_sum_q    <= '0;
      res_id_q     <= '0;
      served_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      res_sum_q    <= res_sum_d;
      res_id_q     <= res_id_d;
      served_cnt_q <= served_cnt_d;
    end
  end

  // FSM outputs and status.
  always_comb begin
    res_valid_o  = (state_q == StFull);
    res_sum_o    = res_sum_q;
    res_id_o     = res_id_q;
    served_cnt_o = served_cnt_q;
    busy_o       = (state_q == StFull) | (|req_valid_i);
  end

endmodule
